// File: rtl/rca_seq_adder_pkg.sv
// Shared types and helpers for the byte-serial add/subtract controller.
package rca_seq_adder_pkg;

  // Controller states. The encoding is exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a byte index able to address nbytes bytes (at least one bit).
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_adder_rca_8.sv
// 8-bit ripple-carry adder: the shared byte datapath of the sequencer.
module rca_8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] s_o,
  output logic       cout_o
);

  // Ripple the carry through eight full-adder cells, LSB first.
  always_comb begin
    logic carry;
    carry = cin_i;
    s_o   = '0;
    for (int i = 0; i < 8; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/rca_seq_adder.sv
// Byte-serial wide adder/subtractor. One shared rca_8 processes one byte of
// the captured operands per clock; the inter-byte carry lives in carry_q.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE. out_valid, once raised, stays
// high with sum/cout/ovf stable until a cycle with out_ready high.
module rca_seq_adder
  import rca_seq_adder_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  localparam int            IW       = idx_width(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t         state_q;
  logic [W-1:0]   op_a_q;
  logic [W-1:0]   op_b_q;     // already inverted for subtraction
  logic           carry_q;
  logic [IW-1:0]  idx_q;
  logic [W-1:0]   sum_q;
  logic [W-1:0]   sum_d;
  logic           cout_q;
  logic           ovf_q;
  logic           ovf_d;
  logic           out_valid_q;

  logic [IW+2:0]  byte_base;
  logic [7:0]     byte_a;
  logic [7:0]     byte_b;
  logic [7:0]     rca_s;
  logic           rca_cout;

  // Select the operand bytes addressed by the byte index.
  always_comb begin
    byte_base = {idx_q, 3'b000};
    byte_a    = op_a_q[byte_base +: 8];
    byte_b    = op_b_q[byte_base +: 8];
  end

  rca_8 u_rca (
    .a_i    (byte_a),
    .b_i    (byte_b),
    .cin_i  (carry_q),
    .s_o    (rca_s),
    .cout_o (rca_cout)
  );

  // Merge the fresh byte into the result and form signed overflow, which is
  // only meaningful on the MSB byte.
  always_comb begin
    sum_d                 = sum_q;
    sum_d[byte_base +: 8] = rca_s;
    ovf_d = (op_a_q[W-1] == op_b_q[W-1]) & (rca_s[7] != op_a_q[W-1]);
  end

  // Controller FSM with registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            // Subtraction is a + ~b + 1; cin is ignored in that mode.
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_d;
          carry_q <= rca_cout;
          if (idx_q == LAST_IDX) begin
            cout_q      <= rca_cout;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Bench for rca_seq_adder (NBYTES=4): directed plan vectors, randomized
// operations, back-pressure, back-to-back throughput and mid-run reset.
module tb_rca_seq_adder;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Expected {ovf, cout, sum} for each accepted operation, oldest first.
  logic [W+1:0] exp_q[$];

  rca_seq_adder #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Plain integer arithmetic: unsigned result modulo 2^W, cout as carry out
  // (for sub: 1 when a >= b, i.e. no borrow), ovf as the true signed result
  // falling outside the W-bit two's-complement range.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c_in, input logic is_sub);
    longint sx, sy, sr;
    longint smax, smin;
    logic [W:0] u;
    logic c, o;
    smax = (64'sd1 <<< (W - 1)) - 1;
    smin = -(64'sd1 <<< (W - 1));
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (is_sub) begin
      u  = {1'b0, x} - {1'b0, y};
      c  = (x >= y);
      sr = sx - sy;
    end else begin
      u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c_in};
      c  = u[W];
      sr = sx + sy + longint'(c_in);
    end
    o = (sr > smax) || (sr < smin);
    return {o, c, u[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation: handshake in, bounded wait for result, check latency and
  // result against the scoreboard, then accept the result.
  task automatic exercise_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                             input logic op_cin, input logic op_sub, input string tag);
    logic [W+1:0] e;
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    a = op_a; b = op_b; cin = op_cin; sub = op_sub; in_valid = 1'b1;
    exp_q.push_back(model(op_a, op_b, op_cin, op_sub));
    tick();
    in_valid = 1'b0;
    // Operand pins change while busy; the captured copy must be used.
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    e = exp_q.pop_front();
    n_vec++;
    if (cyc !== NBYTES) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, cyc, NBYTES);
    end
    n_vec++;
    if (sum !== e[W-1:0]) begin
      n_err++;
      $display("FAIL %s sum: got %h, expected %h", tag, sum, e[W-1:0]);
    end
    n_vec++;
    if (cout !== e[W]) begin
      n_err++;
      $display("FAIL %s cout: got %b, expected %b", tag, cout, e[W]);
    end
    n_vec++;
    if (ovf !== e[W+1]) begin
      n_err++;
      $display("FAIL %s ovf: got %b, expected %b", tag, ovf, e[W+1]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== e[W-1:0]) begin
      n_err++;
      $display("FAIL %s release: out_valid=%b in_ready=%b sum=%h, expected 0 1 %h",
               tag, out_valid, in_ready, sum, e[W-1:0]);
    end
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset in_ready: got %b, expected 1", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset out_valid: got %b, expected 0", out_valid);
    end
    n_vec++;
    if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset outputs: sum=%h cout=%b ovf=%b, expected 0 0 0", sum, cout, ovf);
    end
  endtask

  task automatic test_directed();
    exercise_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "add_carry_byte");
    exercise_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_wrap");
    exercise_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, "add_cin");
    exercise_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, "sub_neg");
    exercise_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, "sub_pos");
    exercise_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_ovf");
    exercise_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, "sub_ovf");
    exercise_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, "sub_equal");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) rb = ra;
      if ($urandom_range(0, 4) == 0) ra = {1'b0, {(W-1){1'b1}}};
      exercise_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_back_pressure();
    logic [W+1:0] e;
    int cyc;
    a = 32'hCAFE_0123; b = 32'h0BAD_F00D; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    e = model(32'hCAFE_0123, 32'h0BAD_F00D, 1'b1, 1'b0);
    tick();
    // Pulse in_valid with different operands while busy.
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (out_valid !== 1'b1 || sum !== e[W-1:0] || cout !== e[W] || ovf !== e[W+1]) begin
      n_err++;
      $display("FAIL bp_result: valid=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
               out_valid, sum, cout, ovf, e[W-1:0], e[W], e[W+1]);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e[W-1:0] ||
          cout !== e[W] || ovf !== e[W+1]) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b sum=%h cout=%b ovf=%b, expected 1 0 %h %b %b",
                 k, out_valid, in_ready, sum, cout, ovf, e[W-1:0], e[W], e[W+1]);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] e;
    logic acc, consume;
    int cyc, n_acc, last_acc;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; n_acc = 0; last_acc = -1;
    while (n_acc < 4 && cyc < 200) begin
      acc     = in_valid & in_ready;
      consume = out_valid & out_ready;
      if (consume) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({ovf, cout, sum} !== e) begin
          n_err++;
          $display("FAIL b2b_result: got %b %b %h, expected %b %b %h",
                   ovf, cout, sum, e[W+1], e[W], e[W-1:0]);
        end
      end
      if (acc) exp_q.push_back(model(a, b, cin, sub));
      tick();
      cyc++;
      if (acc) begin
        if (last_acc >= 0) begin
          n_vec++;
          if (cyc - last_acc !== NBYTES + 2) begin
            n_err++;
            $display("FAIL b2b_interval: got %0d cycles, expected %0d", cyc - last_acc, NBYTES + 2);
          end
        end
        last_acc = cyc;
        n_acc++;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (n_acc != 4) begin
      n_err++;
      $display("FAIL b2b_timeout: accepted %0d operations, expected 4", n_acc);
    end
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL b2b_drain: scoreboard empty, expected 1 pending result");
    end else begin
      e = exp_q.pop_front();
      if (out_valid !== 1'b1 || {ovf, cout, sum} !== e) begin
        n_err++;
        $display("FAIL b2b_drain: valid=%b got %b %b %h, expected 1 %b %b %h",
                 out_valid, ovf, cout, sum, e[W+1], e[W], e[W-1:0]);
      end
    end
    tick();
    out_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_op();
    // Leave sum, cout and ovf all non-zero first.
    exercise_op(32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0, "pre_reset");
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: valid=%b sum=%h cout=%b ovf=%b in_ready=%b, expected 0 0 0 0 1",
               out_valid, sum, cout, ovf, in_ready);
    end
    exercise_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "post_reset");
    n_vec++;
    if (sum !== 32'h2345_6789) begin
      n_err++;
      $display("FAIL post_reset_const: got %h, expected 23456789", sum);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
